// File: rtl/fetch_unit_pkg.sv
// Definitions shared by fetch and decode: opcodes, fetch FSM states, queue entry layout, B/J immediates.
package fetch_unit_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [0:0] {
    REQ  = 1'b0,
    WAIT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } iq_entry_t;

  // Sign-extended byte offsets of conditional branches and JAL.
  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction memory, branch predictor lookup, redirect and decode-queue head.
interface fetch_unit_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic [31:0] pred_addr;
  logic        pred_taken;
  logic        flush;
  logic [31:0] flush_pc;
  logic        iq_valid;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic        iq_pred;
  logic        iq_ready;

  modport master (
    output mem_req, mem_addr, pred_addr, iq_valid, iq_inst, iq_pc, iq_pred,
    input  mem_valid, mem_data, pred_taken, flush, flush_pc, iq_ready
  );

  modport slave (
    input  mem_req, mem_addr, pred_addr, iq_valid, iq_inst, iq_pc, iq_pred,
    output mem_valid, mem_data, pred_taken, flush, flush_pc, iq_ready
  );

endinterface

// File: rtl/fetch_iq.sv
// Synchronous circular FIFO with clear; head read from storage, so an entry shows the cycle after its push.
// Push while full / pop while empty are ignored; en=0 holds every register.
module fetch_iq #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 65
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (en) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en && do_push && !clr) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: one outstanding imem request, predictor-steered next PC, entry on iq_* one cycle after the response.
// Issue stalls while the queue is full; rdy=0 freezes all state. FETCH_JAL_EN also redirects JAL in fetch.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IQ_DEPTH = 4,
  parameter int          IQ_AW    = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          rdy,
  fetch_unit_if.master fe
);

`ifdef FETCH_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  fetch_state_e   state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    pred_addr_q, pred_addr_d;
  logic           discard_q, discard_d;
  logic [31:0]    inst, next_pc;
  logic           issue, resp, take_br, take_jal;
  logic           iq_push, iq_pop, iq_clr, iq_full, iq_empty;
  logic [IQ_AW:0] iq_count;
  iq_entry_t      push_ent, head_ent;

  assign inst     = fe.mem_data;
  assign resp     = (state_q == WAIT) && fe.mem_valid;
  assign take_br  = (inst[6:0] == OP_BRANCH) && fe.pred_taken;
  assign take_jal = JAL_EN && (inst[6:0] == OP_JAL);

  // addr_q is the PC of the request in flight; pc_q may already hold a redirect target.
  always_comb begin
    next_pc = addr_q + 32'd4;
    if (take_jal)     next_pc = addr_q + imm_j(inst);
    else if (take_br) next_pc = addr_q + imm_b(inst);
  end

  assign push_ent    = '{inst: inst, pc: addr_q, pred: (take_br || take_jal)};
  assign pred_addr_d = (rdy && resp) ? addr_q : pred_addr_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    discard_d = discard_q;
    issue     = 1'b0;
    iq_push   = 1'b0;
    iq_pop    = 1'b0;
    iq_clr    = 1'b0;
    if (fe.flush) begin
      iq_clr = 1'b1;
      pc_d   = fe.flush_pc;
      if ((state_q == WAIT) && !fe.mem_valid) begin
        discard_d = 1'b1;
      end else begin
        state_d   = REQ;
        discard_d = 1'b0;
      end
    end else begin
      iq_pop = fe.iq_ready && (iq_count != '0);
      case (state_q)
        REQ: begin
          if (!iq_full) begin
            issue   = 1'b1;
            addr_d  = pc_q;
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (fe.mem_valid) begin
            state_d   = REQ;
            discard_d = 1'b0;
            if (!discard_q) begin
              iq_push = 1'b1;
              pc_d    = next_pc;
            end
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      discard_q   <= 1'b0;
      pred_addr_q <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      discard_q   <= discard_d;
      pred_addr_q <= pred_addr_d;
    end
  end

  fetch_iq #(
    .DEPTH (IQ_DEPTH),
    .AW    (IQ_AW),
    .W     ($bits(iq_entry_t))
  ) u_iq (
    .clk      (clk),
    .rst      (rst),
    .en       (rdy),
    .clr      (iq_clr),
    .push     (iq_push),
    .push_dat (push_ent),
    .pop      (iq_pop),
    .head_dat (head_ent),
    .count    (iq_count),
    .full     (iq_full),
    .empty    (iq_empty)
  );

  // The request stays asserted in WAIT even under rdy=0 so the memory never sees it drop.
  assign fe.mem_req   = !rst && ((state_q == WAIT) || (rdy && issue));
  assign fe.mem_addr  = (state_q == WAIT) ? addr_q : pc_q;
  assign fe.pred_addr = rst ? 32'h0 : pred_addr_d;
  assign fe.iq_valid  = !iq_empty;
  assign fe.iq_inst   = head_ent.inst;
  assign fe.iq_pc     = head_ent.pc;
  assign fe.iq_pred   = head_ent.pred;

  assert property (@(posedge clk) disable iff (rst) (rdy && iq_push) |-> !iq_full);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level model of fetch order and queue contents.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          IQ_DEPTH = 4;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    bit          pred;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .IQ_DEPTH (IQ_DEPTH),
    .IQ_AW    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .fe  (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] prog [256];
  bit          ptbl [16];

  assign bus.pred_taken = ptbl[bus.pred_addr[5:2]];

  int n_checks = 0;
  int n_fail   = 0;

  int p_rdy, p_flush, p_ready, lat_max;

  bit          outst, dropped;
  int          lat_cnt;
  logic [31:0] req_addr, exp_pc;
  ent_t        exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] imem(input logic [31:0] a);
    return prog[a[9:2]];
  endfunction

  // Next PC and prediction bit straight from the architectural rules.
  function automatic void model_next(input logic [31:0] inst, input logic [31:0] pc, input bit tk,
                                     output logic [31:0] nxt, output bit pred);
    logic signed [12:0] boff;
    logic signed [20:0] joff;
    int off;
    boff = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    joff = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    nxt  = pc + 32'd4;
    pred = 1'b0;
    if (inst[6:0] == 7'b1100011 && tk) begin
      off  = boff;
      nxt  = pc + $unsigned(off);
      pred = 1'b1;
    end
`ifdef FETCH_JAL_EN
    if (inst[6:0] == 7'b1101111) begin
      off  = joff;
      nxt  = pc + $unsigned(off);
      pred = 1'b1;
    end
`endif
  endfunction

  task automatic do_reset();
    rst           = 1'b1;
    rdy           = 1'b1;
    bus.flush     = 1'b0;
    bus.flush_pc  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_data  = '0;
    bus.iq_ready  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_iq_valid", bus.iq_valid, 0);
    chk("rst_pred_addr", bus.pred_addr, 0);
    rst     = 1'b0;
    outst   = 1'b0;
    dropped = 1'b0;
    lat_cnt = 0;
    exp_q.delete();
    exp_pc  = RESET_PC;
  endtask

  // One clock: drive at the negedge, observe after settling, advance model, wait for next negedge.
  task automatic cycle();
    ent_t        e;
    logic [31:0] nxt;
    bit          pr, exp_req;
    rdy           = ($urandom_range(99) < p_rdy);
    bus.flush     = rdy && ($urandom_range(99) < p_flush);
    bus.flush_pc  = $urandom() & 32'hFFFF_FFFC;
    bus.iq_ready  = ($urandom_range(99) < p_ready);
    bus.mem_valid = 1'b0;
    bus.mem_data  = $urandom();
    if (outst) begin
      if (lat_cnt == 0) begin
        bus.mem_valid = 1'b1;
        bus.mem_data  = imem(req_addr);
      end else begin
        lat_cnt--;
      end
    end
    #1;
    exp_req = !outst && rdy && !bus.flush && (exp_q.size() < IQ_DEPTH);
    chk("mem_req", bus.mem_req, outst ? 1 : exp_req);
    if (outst) chk("mem_addr_hold", bus.mem_addr, req_addr);
    chk("iq_valid", bus.iq_valid, exp_q.size() != 0);
    if (rdy) begin
      if (bus.iq_ready && !bus.flush && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("iq_inst", bus.iq_inst, e.inst);
        chk("iq_pc", bus.iq_pc, e.pc);
        chk("iq_pred", bus.iq_pred, e.pred);
      end
      if (bus.flush) begin
        exp_q.delete();
        exp_pc = bus.flush_pc;
        if (outst) dropped = 1'b1;
      end
      if (outst && bus.mem_valid) begin
        outst = 1'b0;
        if (!dropped) begin
          chk("pred_addr", bus.pred_addr, req_addr);
          model_next(bus.mem_data, req_addr, ptbl[req_addr[5:2]], nxt, pr);
          exp_q.push_back('{inst: bus.mem_data, pc: req_addr, pred: pr});
          exp_pc = nxt;
        end
        dropped = 1'b0;
      end else if (!outst && bus.mem_req) begin
        chk("req_addr", bus.mem_addr, exp_pc);
        outst    = 1'b1;
        dropped  = 1'b0;
        req_addr = bus.mem_addr;
        lat_cnt  = $urandom_range(lat_max, 0);
      end
    end
    @(negedge clk);
  endtask

  // prog_kind: 0 NOPs + beq +16 at 0x8, 1 NOPs + jal -8 at 0x20, 2 random mix.
  // taken_kind: 0 never, 1 always, 2 random per predictor slot.
  task automatic run_phase(input int prog_kind, input int taken_kind, input int pr, input int pf,
                           input int prd, input int lm, input int ncyc);
    logic [31:0] r;
    int k;
    for (int i = 0; i < 256; i++) begin
      r = $urandom();
      k = $urandom_range(9);
      if (prog_kind != 2)  prog[i] = 32'h0000_0013;
      else if (k < 4)      prog[i] = {r[31:7], 7'b0010011};
      else if (k < 7)      prog[i] = {r[31:7], 7'b1100011};
      else if (k < 9)      prog[i] = {r[31:7], 7'b1101111};
      else                 prog[i] = r;
    end
    if (prog_kind == 0) prog[2] = 32'h0000_0863;
    if (prog_kind == 1) prog[8] = 32'hFF9F_F0EF;
    for (int i = 0; i < 16; i++) ptbl[i] = (taken_kind == 2) ? 1'($urandom_range(1)) : (taken_kind == 1);
    p_rdy   = pr;
    p_flush = pf;
    p_ready = prd;
    lat_max = lm;
    do_reset();
    repeat (ncyc) cycle();
  endtask

  initial begin
    run_phase(0, 0, 100, 0, 100, 0, 20);
    run_phase(0, 1, 100, 0, 100, 0, 20);
    run_phase(1, 2, 100, 0, 100, 0, 40);
    run_phase(2, 2, 100, 0, 0, 0, 40);
    run_phase(2, 2, 90, 0, 5, 2, 400);
    run_phase(2, 2, 85, 4, 60, 3, 1500);
    run_phase(2, 2, 90, 25, 70, 4, 1000);
    run_phase(2, 2, 50, 10, 50, 3, 600);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
